// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: RV32I load/store funct3 codes,
// FSM states, byte-strobe patterns and store/misalignment helpers.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] STRB_NONE    = 4'b0000;
  localparam logic [3:0] STRB_BYTE    = 4'b0001;
  localparam logic [3:0] STRB_HALF_LO = 4'b0011;
  localparam logic [3:0] STRB_HALF_HI = 4'b1100;
  localparam logic [3:0] STRB_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } mem_state_e;

  // Unknown store widths fall back to a full-word write.
  function automatic logic [3:0] storeStrobe(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] strb;
    case (f3)
      F3_SB:   strb = STRB_BYTE << lane;
      F3_SH:   strb = lane[1] ? STRB_HALF_HI : STRB_HALF_LO;
      default: strb = STRB_WORD;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] storeData(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] data;
    case (f3)
      F3_SB:   data = {4{wdata[7:0]}};
      F3_SH:   data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

  function automatic logic isMisaligned(input logic isLoad, input logic [2:0] f3,
                                        input logic [1:0] lane);
    logic mis;
    mis = (lane != 2'b00);
    if (isLoad) begin
      case (f3)
        F3_LB, F3_LBU: mis = 1'b0;
        F3_LH, F3_LHU: mis = lane[0];
        default:       mis = (lane != 2'b00);
      endcase
    end else begin
      case (f3)
        F3_SB:   mis = 1'b0;
        F3_SH:   mis = lane[0];
        default: mis = (lane != 2'b00);
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and data memory
// (slave): valid/ready request channel plus a single-beat load response.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_we;
  logic [3:0]        dmem_wstrb;
  logic [31:0]       dmem_wdata;
  logic              dmem_rsp_valid;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req_valid,
    output dmem_addr,
    output dmem_we,
    output dmem_wstrb,
    output dmem_wdata,
    input  dmem_req_ready,
    input  dmem_rsp_valid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req_valid,
    input  dmem_addr,
    input  dmem_we,
    input  dmem_wstrb,
    input  dmem_wdata,
    output dmem_req_ready,
    output dmem_rsp_valid,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_load_align.sv
// Load-data aligner: picks the addressed byte/halfword out of the read word and
// sign- or zero-extends it according to the RV32I load funct3.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel = rdata_i[{lane_i, 3'b000} +: 8];
  // Halfwords only look at addr[1]; addr[0] is either trapped upstream or ignored.
  assign halfSel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    case (funct3_i)
      F3_LB:   result_o = {{24{byteSel[7]}}, byteSel};
      F3_LBU:  result_o = {24'h000000, byteSel};
      F3_LH:   result_o = {{16{halfSel[15]}}, halfSel};
      F3_LHU:  result_o = {16'h0000, halfSel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues one bus access per load/store and stalls
// the pipeline until it completes. Optional trap of misaligned accesses: MEM_MISALIGN_CHECK_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_MEM,
  input  logic              mem_write_MEM,
  input  logic [2:0]        funct3_MEM,
  input  logic [ADDR_W-1:0] ALU_OUT_MEM,
  input  logic [31:0]       wdata_MEM,
  output logic [31:0]       red_data_MEM,
  output logic              pipe_write,
  output logic              misalign_MEM,
  mem_access_unit_if.master dmem
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q, we_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       redData_q, redData_d;
  logic [31:0]       alignedData;
  logic              access;
  logic              bypassBus;
  logic              pipeWrite;
`ifdef MEM_MISALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
`endif

  assign access = mem_read_MEM | mem_write_MEM;

  // A misaligned access never reaches the bus; it completes straight through DONE.
`ifdef MEM_MISALIGN_CHECK_EN
  assign bypassBus = isMisaligned(mem_read_MEM, funct3_MEM, ALU_OUT_MEM[1:0]);
`else
  assign bypassBus = 1'b0;
`endif

  mem_load_align u_align (
    .rdata_i  (dmem.dmem_rdata),
    .lane_i   (lane_q),
    .funct3_i (funct3_q),
    .result_o (alignedData)
  );

  always_comb begin
    state_d   = state_q;
    reqAddr_d = reqAddr_q;
    lane_d    = lane_q;
    funct3_d  = funct3_q;
    we_d      = we_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    redData_d = redData_q;
    pipeWrite = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!access) begin
          pipeWrite = 1'b1;
        end else if (bypassBus) begin
          state_d = DONE;
`ifdef MEM_MISALIGN_CHECK_EN
          misalign_d = 1'b1;
`endif
          if (mem_read_MEM) begin
            redData_d = '0;
          end
        end else begin
          // Read wins when both controls are set, so the access becomes a load.
          state_d   = REQ;
          reqAddr_d = {ALU_OUT_MEM[ADDR_W-1:2], 2'b00};
          lane_d    = ALU_OUT_MEM[1:0];
          funct3_d  = funct3_MEM;
          we_d      = ~mem_read_MEM;
          wstrb_d   = mem_read_MEM ? STRB_NONE : storeStrobe(funct3_MEM, ALU_OUT_MEM[1:0]);
          wdata_d   = mem_read_MEM ? 32'h0 : storeData(funct3_MEM, wdata_MEM);
        end
      end
      REQ: begin
        if (dmem.dmem_req_ready) begin
          state_d = we_q ? DONE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dmem.dmem_rsp_valid) begin
          redData_d = alignedData;
          state_d   = DONE;
        end
      end
      DONE: begin
        pipeWrite = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      reqAddr_q  <= '0;
      lane_q     <= 2'b00;
      funct3_q   <= 3'b000;
      we_q       <= 1'b0;
      wstrb_q    <= STRB_NONE;
      wdata_q    <= 32'h0;
      redData_q  <= 32'h0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      reqAddr_q  <= reqAddr_d;
      lane_q     <= lane_d;
      funct3_q   <= funct3_d;
      we_q       <= we_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      redData_q  <= redData_d;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign dmem.dmem_req_valid = (state_q == REQ);
  assign dmem.dmem_addr      = reqAddr_q;
  assign dmem.dmem_we        = we_q;
  assign dmem.dmem_wstrb     = wstrb_q;
  assign dmem.dmem_wdata     = wdata_q;
  assign red_data_MEM        = redData_q;
  assign pipe_write          = pipeWrite;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_MEM        = misalign_q;
`else
  assign misalign_MEM        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: expected access results are queued when a
// load/store is launched and compared once the unit releases the pipeline.
module tb_mem_access_unit;
  import mem_pkg::*;

  typedef struct {
    logic [31:0] busAddr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] red;
    int          stalls;
    logic        bus;
    logic        mis;
  } exp_t;

  typedef struct {
    logic        done;
    int          stalls;
    int          reqCycles;
    logic        unstable;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] red;
    logic        mis;
  } obs_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] expVal;
    logic [31:0] busAddr;
    logic [3:0]  strb;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read_MEM = 1'b0;
  logic        mem_write_MEM = 1'b0;
  logic [2:0]  funct3_MEM = 3'b000;
  logic [31:0] ALU_OUT_MEM = 32'h0;
  logic [31:0] wdata_MEM = 32'h0;
  logic [31:0] red_data_MEM;
  logic        pipe_write;
  logic        misalign_MEM;

  int          errorCount = 0;
  int          checkCount = 0;
  logic [31:0] lastRed = 32'h0;
  exp_t        scoreQ[$];

  mem_access_unit_if #(.ADDR_W(32)) dmem ();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read_MEM  (mem_read_MEM),
    .mem_write_MEM (mem_write_MEM),
    .funct3_MEM    (funct3_MEM),
    .ALU_OUT_MEM   (ALU_OUT_MEM),
    .wdata_MEM     (wdata_MEM),
    .red_data_MEM  (red_data_MEM),
    .pipe_write    (pipe_write),
    .misalign_MEM  (misalign_MEM),
    .dmem          (dmem.master)
  );

  always #5 clk = ~clk;

  initial begin
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_rdata     = 32'h0;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one access and plays the memory side; returns what the unit did.
  task automatic runAccess(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdataIn, input int readyDelay,
                           output obs_t o);
    logic hsLoad;
    int   c;
    o = '{default: '0};
    @(posedge clk); #1;
    mem_read_MEM = rd; mem_write_MEM = wr; funct3_MEM = f3;
    ALU_OUT_MEM = addr; wdata_MEM = wd;
    dmem.dmem_req_ready = (readyDelay == 0);
    dmem.dmem_rsp_valid = 1'b0;
    c = 0;
    while (!o.done && c < 60) begin
      @(negedge clk);
      if (pipe_write) begin
        o.done = 1'b1; o.red = red_data_MEM; o.mis = misalign_MEM;
      end else begin
        o.stalls++;
        hsLoad = 1'b0;
        if (dmem.dmem_req_valid) begin
          if (o.reqCycles == 0) begin
            o.addr = dmem.dmem_addr; o.we = dmem.dmem_we;
            o.strb = dmem.dmem_wstrb; o.wdata = dmem.dmem_wdata;
          end else if ({dmem.dmem_addr, dmem.dmem_we, dmem.dmem_wstrb, dmem.dmem_wdata}
                       !== {o.addr, o.we, o.strb, o.wdata}) begin
            o.unstable = 1'b1;
          end
          o.reqCycles++;
          hsLoad = dmem.dmem_req_ready && !dmem.dmem_we;
        end
        @(posedge clk); #1;
        c++;
        dmem.dmem_req_ready = (c >= readyDelay);
        dmem.dmem_rsp_valid = hsLoad;
        dmem.dmem_rdata     = hsLoad ? rdataIn : $urandom;
      end
    end
  endtask

  task automatic idleBus();
    @(posedge clk); #1;
    mem_read_MEM = 1'b0; mem_write_MEM = 1'b0;
    dmem.dmem_req_ready = 1'b0; dmem.dmem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checkCount++; if (pipe_write !== 1'b1) begin errorCount++; $display("[TB] FAIL reset pipe_write got %b want 1", pipe_write); end
    checkCount++; if (dmem.dmem_req_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset req_valid got %b want 0", dmem.dmem_req_valid); end
    checkCount++; if (dmem.dmem_we !== 1'b0) begin errorCount++; $display("[TB] FAIL reset we got %b want 0", dmem.dmem_we); end
    checkCount++; if (dmem.dmem_addr !== 32'h0) begin errorCount++; $display("[TB] FAIL reset addr got %h want 0", dmem.dmem_addr); end
    checkCount++; if (dmem.dmem_wstrb !== 4'h0) begin errorCount++; $display("[TB] FAIL reset wstrb got %b want 0000", dmem.dmem_wstrb); end
    checkCount++; if (dmem.dmem_wdata !== 32'h0) begin errorCount++; $display("[TB] FAIL reset wdata got %h want 0", dmem.dmem_wdata); end
    checkCount++; if (red_data_MEM !== 32'h0) begin errorCount++; $display("[TB] FAIL reset red_data got %h want 0", red_data_MEM); end
    checkCount++; if (misalign_MEM !== 1'b0) begin errorCount++; $display("[TB] FAIL reset misalign got %b want 0", misalign_MEM); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_load_word();
    obs_t o; exp_t e;
    scoreQ.push_back('{32'h100, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 3, 1'b1, 1'b0});
    runAccess(1'b1, 1'b0, F3_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, o);
    e = scoreQ.pop_front();
    checkCount++; if (!o.done) begin errorCount++; $display("[TB] FAIL lw timeout got no release want release"); end
    checkCount++; if (o.stalls != e.stalls) begin errorCount++; $display("[TB] FAIL lw stalls got %0d want %0d", o.stalls, e.stalls); end
    checkCount++; if (o.red !== e.red) begin errorCount++; $display("[TB] FAIL lw red_data got %h want %h", o.red, e.red); end
    checkCount++; if (o.addr !== e.busAddr) begin errorCount++; $display("[TB] FAIL lw addr got %h want %h", o.addr, e.busAddr); end
    checkCount++; if (o.we !== e.we) begin errorCount++; $display("[TB] FAIL lw we got %b want %b", o.we, e.we); end
    checkCount++; if (o.mis !== e.mis) begin errorCount++; $display("[TB] FAIL lw misalign got %b want %b", o.mis, e.mis); end
    lastRed = e.red;
    idleBus();
    @(negedge clk);
    checkCount++; if (red_data_MEM !== lastRed) begin errorCount++; $display("[TB] FAIL lw hold red_data got %h want %h", red_data_MEM, lastRed); end
  endtask

  task automatic test_load_extend();
    vec_t tab[$];
    obs_t o; exp_t e;
    tab.push_back('{F3_LB,  32'h103, 32'h80FF0000, 32'hFFFFFF80, 32'h100, 4'h0});
    tab.push_back('{F3_LBU, 32'h103, 32'h80FF0000, 32'h00000080, 32'h100, 4'h0});
    tab.push_back('{F3_LH,  32'h102, 32'h80FF0000, 32'hFFFF80FF, 32'h100, 4'h0});
    tab.push_back('{F3_LHU, 32'h100, 32'h12348001, 32'h00008001, 32'h100, 4'h0});
    tab.push_back('{F3_LH,  32'h100, 32'h00008001, 32'hFFFF8001, 32'h100, 4'h0});
    tab.push_back('{F3_LB,  32'h101, 32'h11227F33, 32'h0000007F, 32'h100, 4'h0});
    tab.push_back('{F3_LBU, 32'h102, 32'h11C27F33, 32'h000000C2, 32'h100, 4'h0});
    tab.push_back('{3'b011, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D, 32'h104, 4'h0});
`ifndef MEM_MISALIGN_CHECK_EN
    tab.push_back('{F3_LH,  32'h101, 32'h1234F00D, 32'hFFFFF00D, 32'h100, 4'h0});
    tab.push_back('{F3_LW,  32'h10B, 32'h0BADCAFE, 32'h0BADCAFE, 32'h108, 4'h0});
`endif
    foreach (tab[i]) begin
      scoreQ.push_back('{tab[i].busAddr, 1'b0, 4'h0, 32'h0, tab[i].expVal, 3, 1'b1, 1'b0});
      runAccess(1'b1, 1'b0, tab[i].f3, tab[i].addr, 32'h0, tab[i].data, 0, o);
      e = scoreQ.pop_front();
      checkCount++; if (!o.done) begin errorCount++; $display("[TB] FAIL load[%0d] timeout got no release want release", i); end
      checkCount++; if (o.red !== e.red) begin errorCount++; $display("[TB] FAIL load[%0d] red_data got %h want %h", i, o.red, e.red); end
      checkCount++; if (o.addr !== e.busAddr) begin errorCount++; $display("[TB] FAIL load[%0d] addr got %h want %h", i, o.addr, e.busAddr); end
      checkCount++; if (o.stalls != e.stalls) begin errorCount++; $display("[TB] FAIL load[%0d] stalls got %0d want %0d", i, o.stalls, e.stalls); end
      lastRed = e.red;
      idleBus();
    end
  endtask

  task automatic test_store();
    vec_t tab[$];
    obs_t o; exp_t e;
    tab.push_back('{F3_SB,  32'h101, 32'h000000AB, 32'hABABABAB, 32'h100, 4'b0010});
    tab.push_back('{F3_SB,  32'h103, 32'h12345678, 32'h78787878, 32'h100, 4'b1000});
    tab.push_back('{F3_SH,  32'h102, 32'h0000BEEF, 32'hBEEFBEEF, 32'h100, 4'b1100});
    tab.push_back('{F3_SH,  32'h100, 32'hFFFF1234, 32'h12341234, 32'h100, 4'b0011});
    tab.push_back('{F3_SW,  32'h104, 32'h12345678, 32'h12345678, 32'h104, 4'b1111});
    tab.push_back('{3'b111, 32'h108, 32'hA5A50F0F, 32'hA5A50F0F, 32'h108, 4'b1111});
`ifndef MEM_MISALIGN_CHECK_EN
    tab.push_back('{F3_SW,  32'h106, 32'h01020304, 32'h01020304, 32'h104, 4'b1111});
`endif
    foreach (tab[i]) begin
      scoreQ.push_back('{tab[i].busAddr, 1'b1, tab[i].strb, tab[i].expVal, lastRed, 2, 1'b1, 1'b0});
      runAccess(1'b0, 1'b1, tab[i].f3, tab[i].addr, tab[i].data, 32'h0, 0, o);
      e = scoreQ.pop_front();
      checkCount++; if (!o.done) begin errorCount++; $display("[TB] FAIL store[%0d] timeout got no release want release", i); end
      checkCount++; if (o.addr !== e.busAddr) begin errorCount++; $display("[TB] FAIL store[%0d] addr got %h want %h", i, o.addr, e.busAddr); end
      checkCount++; if (o.we !== e.we) begin errorCount++; $display("[TB] FAIL store[%0d] we got %b want %b", i, o.we, e.we); end
      checkCount++; if (o.strb !== e.strb) begin errorCount++; $display("[TB] FAIL store[%0d] wstrb got %b want %b", i, o.strb, e.strb); end
      checkCount++; if (o.wdata !== e.wdata) begin errorCount++; $display("[TB] FAIL store[%0d] wdata got %h want %h", i, o.wdata, e.wdata); end
      checkCount++; if (o.red !== e.red) begin errorCount++; $display("[TB] FAIL store[%0d] red_data hold got %h want %h", i, o.red, e.red); end
      checkCount++; if (o.stalls != e.stalls) begin errorCount++; $display("[TB] FAIL store[%0d] stalls got %0d want %0d", i, o.stalls, e.stalls); end
      idleBus();
    end
  endtask

  task automatic test_ready_stall();
    obs_t o; exp_t e;
    scoreQ.push_back('{32'h200, 1'b1, 4'b1111, 32'h0BADF00D, lastRed, 5, 1'b1, 1'b0});
    runAccess(1'b0, 1'b1, F3_SW, 32'h200, 32'h0BADF00D, 32'h0, 4, o);
    e = scoreQ.pop_front();
    checkCount++; if (!o.done) begin errorCount++; $display("[TB] FAIL stall timeout got no release want release"); end
    checkCount++; if (o.stalls != e.stalls) begin errorCount++; $display("[TB] FAIL stall pipe_write low cycles got %0d want %0d", o.stalls, e.stalls); end
    checkCount++; if (o.reqCycles != 4) begin errorCount++; $display("[TB] FAIL stall req_valid cycles got %0d want 4", o.reqCycles); end
    checkCount++; if (o.unstable !== 1'b0) begin errorCount++; $display("[TB] FAIL stall request fields changed got %b want 0", o.unstable); end
    checkCount++; if (o.wdata !== e.wdata) begin errorCount++; $display("[TB] FAIL stall wdata got %h want %h", o.wdata, e.wdata); end
    checkCount++; if (o.addr !== e.busAddr) begin errorCount++; $display("[TB] FAIL stall addr got %h want %h", o.addr, e.busAddr); end
    idleBus();
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    scoreQ.push_back('{32'h300, 1'b0, 4'h0, 32'h0, 32'h11111111, 3, 1'b1, 1'b0});
    runAccess(1'b1, 1'b0, F3_LW, 32'h300, 32'h0, 32'h11111111, 0, o);
    e = scoreQ.pop_front();
    checkCount++; if (o.red !== e.red || o.stalls != e.stalls) begin errorCount++; $display("[TB] FAIL b2b first got %h/%0d want %h/%0d", o.red, o.stalls, e.red, e.stalls); end
    scoreQ.push_back('{32'h304, 1'b1, 4'b1111, 32'h33333333, 32'h11111111, 2, 1'b1, 1'b0});
    runAccess(1'b0, 1'b1, F3_SW, 32'h304, 32'h33333333, 32'h0, 0, o);
    e = scoreQ.pop_front();
    checkCount++; if (o.addr !== e.busAddr || o.stalls != e.stalls) begin errorCount++; $display("[TB] FAIL b2b store got %h/%0d want %h/%0d", o.addr, o.stalls, e.busAddr, e.stalls); end
    checkCount++; if (o.red !== e.red) begin errorCount++; $display("[TB] FAIL b2b store red_data hold got %h want %h", o.red, e.red); end
    scoreQ.push_back('{32'h308, 1'b0, 4'h0, 32'h0, 32'hFFFFFF92, 3, 1'b1, 1'b0});
    runAccess(1'b1, 1'b0, F3_LB, 32'h30A, 32'h0, 32'h22922222, 0, o);
    e = scoreQ.pop_front();
    checkCount++; if (o.red !== e.red || o.stalls != e.stalls) begin errorCount++; $display("[TB] FAIL b2b third got %h/%0d want %h/%0d", o.red, o.stalls, e.red, e.stalls); end
    lastRed = e.red;
    idleBus();
  endtask

  task automatic test_read_write_both();
    obs_t o; exp_t e;
    scoreQ.push_back('{32'h400, 1'b0, 4'h0, 32'h0, 32'h5A5A5A5A, 3, 1'b1, 1'b0});
    runAccess(1'b1, 1'b1, F3_LW, 32'h400, 32'hFFFFFFFF, 32'h5A5A5A5A, 0, o);
    e = scoreQ.pop_front();
    checkCount++; if (o.we !== e.we) begin errorCount++; $display("[TB] FAIL rw_both we got %b want %b", o.we, e.we); end
    checkCount++; if (o.red !== e.red) begin errorCount++; $display("[TB] FAIL rw_both red_data got %h want %h", o.red, e.red); end
    checkCount++; if (o.stalls != e.stalls) begin errorCount++; $display("[TB] FAIL rw_both stalls got %0d want %0d", o.stalls, e.stalls); end
    lastRed = e.red;
    idleBus();
  endtask

  task automatic test_reset_mid();
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk); #1;
      mem_read_MEM = 1'b1; funct3_MEM = F3_LW; ALU_OUT_MEM = 32'h500;
      dmem.dmem_req_ready = (pass == 1);
      @(posedge clk); #1;
      checkCount++; if (dmem.dmem_req_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL rstmid[%0d] req_valid before reset got %b want 1", pass, dmem.dmem_req_valid); end
      if (pass == 1) begin
        @(posedge clk); #1;
      end
      #2 reset = 1'b0;
      mem_read_MEM = 1'b0; dmem.dmem_req_ready = 1'b0;
      #1;
      checkCount++; if (dmem.dmem_req_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL rstmid[%0d] req_valid in reset got %b want 0", pass, dmem.dmem_req_valid); end
      checkCount++; if (pipe_write !== 1'b1) begin errorCount++; $display("[TB] FAIL rstmid[%0d] pipe_write in reset got %b want 1", pass, pipe_write); end
      @(posedge clk); #1;
      reset = 1'b1;
      dmem.dmem_rsp_valid = 1'b1; dmem.dmem_rdata = 32'h77777777;
      @(posedge clk); #1;
      dmem.dmem_rsp_valid = 1'b0;
      @(negedge clk);
      checkCount++; if (red_data_MEM !== 32'h0) begin errorCount++; $display("[TB] FAIL rstmid[%0d] red_data got %h want 0", pass, red_data_MEM); end
      checkCount++; if (pipe_write !== 1'b1 || dmem.dmem_req_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL rstmid[%0d] idle got pw=%b valid=%b want pw=1 valid=0", pass, pipe_write, dmem.dmem_req_valid); end
    end
    lastRed = 32'h0;
  endtask

`ifdef MEM_MISALIGN_CHECK_EN
  task automatic test_misalign();
    obs_t o; exp_t e;
    scoreQ.push_back('{32'h600, 1'b0, 4'h0, 32'h0, 32'h13572468, 3, 1'b1, 1'b0});
    runAccess(1'b1, 1'b0, F3_LW, 32'h600, 32'h0, 32'h13572468, 0, o);
    e = scoreQ.pop_front();
    checkCount++; if (o.red !== e.red) begin errorCount++; $display("[TB] FAIL mis setup red_data got %h want %h", o.red, e.red); end
    idleBus();
    scoreQ.push_back('{32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 1'b0, 1'b1});
    runAccess(1'b1, 1'b0, F3_LW, 32'h102, 32'h0, 32'hFFFFFFFF, 0, o);
    e = scoreQ.pop_front();
    checkCount++; if (o.reqCycles != 0) begin errorCount++; $display("[TB] FAIL mis lw req_valid cycles got %0d want 0", o.reqCycles); end
    checkCount++; if (o.stalls != e.stalls) begin errorCount++; $display("[TB] FAIL mis lw stalls got %0d want %0d", o.stalls, e.stalls); end
    checkCount++; if (o.mis !== e.mis) begin errorCount++; $display("[TB] FAIL mis lw misalign got %b want %b", o.mis, e.mis); end
    checkCount++; if (o.red !== e.red) begin errorCount++; $display("[TB] FAIL mis lw red_data got %h want %h", o.red, e.red); end
    idleBus();
    @(negedge clk);
    checkCount++; if (misalign_MEM !== 1'b0) begin errorCount++; $display("[TB] FAIL mis drop misalign got %b want 0", misalign_MEM); end
    scoreQ.push_back('{32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 1, 1'b0, 1'b1});
    runAccess(1'b0, 1'b1, F3_SH, 32'h101, 32'h1234, 32'h0, 0, o);
    e = scoreQ.pop_front();
    checkCount++; if (o.reqCycles != 0 || o.mis !== e.mis) begin errorCount++; $display("[TB] FAIL mis sh got req=%0d mis=%b want req=0 mis=%b", o.reqCycles, o.mis, e.mis); end
    idleBus();
  endtask
`endif

  initial begin
    $display("[TB] starting mem_access_unit bench");
    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_ready_stall();
    test_back_to_back();
    test_read_write_both();
    test_reset_mid();
`ifdef MEM_MISALIGN_CHECK_EN
    test_misalign();
`endif
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit: the producer side of the MEM/WB pipeline register. Takes the load/store control and ALU address from the EX/MEM register, runs a valid/ready request plus response handshake to data memory, aligns and sign-extends load data onto `red_data_MEM`, and drives the pipeline-register `write` enable low to stall the pipeline while an access is outstanding.

## Interface
- `ADDR_W`, 32, byte-address width on the data-memory bus
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `mem_read_MEM` in 1: load in MEM stage
- `mem_write_MEM` in 1: store in MEM stage
- `funct3_MEM` in 3: RV32I width/sign code
- `ALU_OUT_MEM` in ADDR_W: effective byte address
- `wdata_MEM` in 32: store data (rs2)
- `red_data_MEM` out 32: aligned, extended load result
- `pipe_write` out 1: `write` enable for IF/ID, ID/EX, EX/MEM, MEM/WB; 0 = stall
- `misalign_MEM` out 1: misaligned-access flag (see Configuration)
- `dmem_req_valid` out 1, `dmem_req_ready` in 1: request handshake
- `dmem_addr` out ADDR_W: word-aligned address (`[1:0]`=0)
- `dmem_we` out 1: 1 store, 0 load
- `dmem_wstrb` out 4, `dmem_wdata` out 32: byte strobes and lane-placed store data
- `dmem_rsp_valid` in 1, `dmem_rdata` in 32: load response

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE: access present (`mem_read_MEM|mem_write_MEM`) -> capture address, funct3, op, store data into request registers; go REQ; `pipe_write`=0 combinationally this cycle. No access -> `pipe_write`=1.
- Read and write both high: treated as load.
- REQ: `dmem_req_valid`=1, request fields stable from registers; on `dmem_req_ready`=1 -> load: WAIT_RSP; store: DONE. `dmem_rsp_valid` ignored in REQ.
- WAIT_RSP: on `dmem_rsp_valid` capture aligned result into `red_data_MEM` register, go DONE.
- DONE: `pipe_write`=1 for exactly one cycle (pipeline advances), then IDLE. Next instruction's access is evaluated in IDLE on the following cycle.
- `pipe_write`=0 in REQ and WAIT_RSP.
- Load align, lane = addr[1:0]: LB (000) / LBU (100) byte at lane, sign/zero extend; LH (001) / LHU (101) half at addr[1]; LW (010) full word. Undefined funct3 treated as LW / SW.
- Store: SB strobe `4'b0001<<addr[1:0]`, byte replicated on all lanes; SH strobe 0011 or 1100 by addr[1], half replicated; SW strobe 1111.
- `red_data_MEM` changes only on load capture; holds otherwise.

## Timing
- Reset values: state IDLE, `red_data_MEM`=0, `pipe_write`=1, `dmem_req_valid`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wstrb`=0, `dmem_wdata`=0, `misalign_MEM`=0.
- Load, zero-wait memory (ready in REQ, response next cycle): 3 stall cycles, `pipe_write` high in 4th cycle.
- Store, ready immediate: 2 stall cycles.
- Request fields change only on IDLE->REQ; held while `dmem_req_valid`=1 and `ready`=0.
- Responder returns response no earlier than the cycle after handshake; one outstanding access max.
- Reset asserted mid-access: immediate return to IDLE, `dmem_req_valid` drops asynchronously; a late `dmem_rsp_valid` in IDLE is ignored.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, skip the bus (IDLE->DONE, 1 stall cycle); `misalign_MEM`=1 during DONE; `red_data_MEM` loads 0.
- Undefined: `misalign_MEM` tied 0; halfword ignores addr[0], word ignores addr[1:0]; all accesses go to the bus.

## Structure
- Package `mem_pkg`: funct3 encodings (LB..LHU, SB/SH/SW), FSM state enum, strobe constants.
- Sub-module `mem_load_align`: combinational lane select + sign/zero extension (rdata, addr[1:0], funct3 -> 32-bit result).

## Test plan
- LW addr 0x100, ready immediate, rdata 0xDEADBEEF next cycle -> `red_data_MEM`=0xDEADBEEF, `pipe_write` low 3 cycles then high 1.
- LB addr 0x103, rdata 0x80FF_0000 -> 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x101, wdata 0x000000AB -> `dmem_wstrb`=0010, `dmem_wdata`=0xABABABAB, `dmem_addr`=0x100, `dmem_we`=1.
- SW with `dmem_req_ready` low 4 cycles -> valid/addr/data held stable, `pipe_write` low 5 cycles total.
- `reset` low while in WAIT_RSP, `dmem_rsp_valid` pulsed after release -> state IDLE, `red_data_MEM`=0, no capture.
- With `MEM_MISALIGN_CHECK_EN`: LW addr 0x102 -> no `dmem_req_valid`, `misalign_MEM`=1 for 1 cycle, `red_data_MEM`=0.
